lsu_store_queue: RTL
====================

// Module: lsu_store_queue
// PURPOSE
//  Committed-store buffer between the commit stage and the DCache write port.
//  The commit stage writes up to COMMIT_WIDTH stores per cycle; this block reads them
//  out oldest-first, one per accepted DCache write request.
//  It also byte-forwards buffered store data to the load pipeline.
// PARAMETERS
//  SQ_DEPTH    default LSU_STORE_QUEU_SIZE (4)  entries; must be a power of 2, >= COMMIT_WIDTH
//  ENQ_WIDTH   default COMMIT_WIDTH (2)         enqueue lanes per cycle
//  ADDR_W      default ADDR_WIDTH (32)          store address width
//  DATA_W      default DATA_WIDTH (32)          store data width; strobe is DATA_W/8 bits
// PORTS
//  clk              in   1              core clock; all state updates on posedge
//  rst_n            in   1              synchronous reset, active-low
//  enq_valid        in   ENQ_WIDTH      per-lane store valid; lane i valid requires lane i-1 valid
//  enq_addr         in   ENQ_WIDTH*32   per-lane byte address
//  enq_data         in   ENQ_WIDTH*32   per-lane data, already aligned to the word lane
//  enq_wstrb        in   ENQ_WIDTH*4    per-lane byte strobe
//  enq_ready        out  1              1 when free entries >= ENQ_WIDTH
//  dc_req_valid     out  1              head entry is present
//  dc_req_ready     in   1              DCache accepts the head entry this cycle
//  dc_req_addr      out  32             head entry address
//  dc_req_data      out  32             head entry data
//  dc_req_wstrb     out  4              head entry strobe
//  ld_query_addr    in   32             load address for forwarding (combinational lookup)
//  fwd_mask         out  4              bytes supplied by the queue
//  fwd_data         out  32             forwarded bytes; bytes with mask=0 are 0
//  sq_count         out  $clog2(SQ_DEPTH)+1  occupied entries
//  sq_empty         out  1              sq_count == 0
// BEHAVIOUR
//  - Storage: circular buffer with head/tail pointers of $clog2(SQ_DEPTH)+1 bits.
//    The MSB is the wrap bit. full = (idx equal && wrap differ); empty = (pointers equal).
//  - Reset (rst_n=0 at posedge): head=tail=0, all entry valid bits 0.
//    Outputs during reset: dc_req_valid=0, enq_ready=1, sq_empty=1, sq_count=0, fwd_mask=0.
//    A reset mid-operation discards all entries and cancels any un-accepted dc request.
//  - Enqueue: the write occurs when enq_ready && enq_valid[i]. n = popcount(enq_valid).
//    Lanes are written at tail, tail+1, ... in lane order, and tail advances by n.
//    enq_valid while !enq_ready is a protocol error. The queue ignores it (no write).
//    The bench asserts on this case.
//  - Dequeue: dc_req_* are driven directly from the head entry registers (0 cycles after it becomes head).
//    They hold stable while dc_req_valid && !dc_req_ready.
//    On dc_req_valid && dc_req_ready the head entry is freed and head advances by 1.
//  - Simultaneous enqueue and dequeue in one cycle are both performed.
//    The count update is count + n - deq.
//  - enq_ready is computed from the registered count only. Same-cycle dequeue does not raise it (no bypass).
//  - An entry enqueued at cycle t is visible on dc_req_* at cycle t+1 at the earliest.
//    There is no enqueue-to-dequeue bypass.
//  - Pointer wrap: index arithmetic is modulo SQ_DEPTH; the wrap bit toggles on overflow.
//  - Forwarding, combinational:
//    - An entry matches when it is valid && addr[31:2] == ld_query_addr[31:2].
//    - Matching entries are merged oldest to youngest (starting at head), so the youngest byte wins.
//    - fwd_mask = OR of the matching strobes.
//    - Entries being enqueued in the current cycle are not visible to forwarding.
//    - The head entry stays visible in the cycle it is accepted.
// STRUCTURE
//  - Shared package lsu_types: typedef struct packed {logic valid; logic[31:0] addr, data; logic[3:0] wstrb;} sq_entry_t;
//    plus the SQ pointer width localparam.
//  - Sub-module sq_fwd_merge: takes the entry array and head index; produces fwd_mask/fwd_data by age-ordered byte merge.
//  - The top level holds the pointers, count, enqueue lane placement and the dequeue handshake.
// TESTING
//  1 Reset:
//    - Stimulus: rst_n=0 for 2 cycles with enq_valid=2'b11.
//    - Required: sq_empty=1, dc_req_valid=0, enq_ready=1; after release sq_count=0.
//  2 Dual enqueue / ordered drain:
//    - Stimulus: enq {0x100,0xAABBCCDD,4'hF},{0x104,0x11223344,4'hF} in one cycle, then dc_req_ready=1.
//    - Required: 0x100 is issued, then 0x104, on consecutive cycles; then sq_empty=1.
//  3 Full / backpressure:
//    - Stimulus: dc_req_ready=0; enqueue 2 stores in each of 2 cycles.
//    - Required: sq_count=4, enq_ready=0, dc_req_* held at the first store.
//    - Then ready=1 for 1 cycle: count=3, enq_ready still 0.
//    - After a 2nd accept: count=2, enq_ready=1.
//  4 Wrap-around:
//    - Stimulus: 10 stores enqueued while draining 1 per cycle.
//    - Required: DCache sees all 10 addresses in enqueue order; pointers wrap twice; no loss or duplicate.
//  5 Simultaneous enq+deq at count=2:
//    - Stimulus: accept the head and enqueue 1 store in the same cycle.
//    - Required: count stays 2; the new store is issued after the older remaining one.
//  6 Forwarding priority:
//    - Stimulus: entries {0x200,0x000000AA,4'b0001} (older) and {0x202,0xBBCC0000,4'b1100}, then {0x200,0x000000EE,4'b0001} (youngest); query 0x201.
//    - Required: fwd_mask=4'b1101, fwd_data=0xBBCC00EE.
//    - Query 0x300: fwd_mask=0, fwd_data=0.

Source files
------------

// File: rtl/lsu_store_queue_pkg.sv
// Shared types and sizing for the committed-store queue.
//   LSU_STORE_QUEU_SIZE : default queue depth (entries)
//   COMMIT_WIDTH        : default enqueue lanes per cycle
//   ADDR_WIDTH/DATA_WIDTH: store address/data widths; strobe is DATA_WIDTH/8
//   sq_entry_t          : one buffered store (valid, addr, data, wstrb)
//   same_word()         : true when two byte addresses fall in the same data word
package lsu_store_queue_pkg;

  localparam int unsigned LSU_STORE_QUEU_SIZE = 4;
  localparam int unsigned COMMIT_WIDTH        = 2;
  localparam int unsigned ADDR_WIDTH          = 32;
  localparam int unsigned DATA_WIDTH          = 32;
  localparam int unsigned STRB_WIDTH          = DATA_WIDTH / 8;
  // Pointer width: index bits plus one wrap bit.
  localparam int unsigned SQ_PTR_W            = $clog2(LSU_STORE_QUEU_SIZE) + 1;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] wstrb;
  } sq_entry_t;

  function automatic logic same_word(input logic [ADDR_WIDTH-1:0] a,
                                     input logic [ADDR_WIDTH-1:0] b);
    return a[ADDR_WIDTH-1:2] == b[ADDR_WIDTH-1:2];
  endfunction

endpackage

// File: rtl/lsu_store_queue_fwd_merge.sv
// Store-to-load byte forwarding merge for the store queue.
// Walks the entries from the head (oldest) towards the youngest; every valid
// entry whose word address matches the query overwrites the bytes it strobes,
// so the youngest matching store supplies each byte.
//   i_entries    : entry array (circular buffer storage)
//   i_head_idx   : index of the oldest entry
//   i_query_addr : load byte address
//   o_fwd_mask   : bytes supplied by the queue
//   o_fwd_data   : merged bytes, zero where o_fwd_mask is 0
module lsu_store_queue_fwd_merge
  import lsu_store_queue_pkg::*;
#(
  parameter int unsigned SQ_DEPTH = LSU_STORE_QUEU_SIZE
) (
  input  sq_entry_t                     i_entries [SQ_DEPTH],
  input  logic [$clog2(SQ_DEPTH)-1:0]   i_head_idx,
  input  logic [ADDR_WIDTH-1:0]         i_query_addr,
  output logic [STRB_WIDTH-1:0]         o_fwd_mask,
  output logic [DATA_WIDTH-1:0]         o_fwd_data
);

  localparam int unsigned IDX_W = $clog2(SQ_DEPTH);

  always_comb begin
    logic [IDX_W-1:0] w_idx;
    sq_entry_t        w_ent;
    o_fwd_mask = '0;
    o_fwd_data = '0;
    w_idx      = '0;
    w_ent      = '0;
    for (int unsigned k = 0; k < SQ_DEPTH; k++) begin
      // Index arithmetic truncates to IDX_W bits, i.e. wraps modulo depth.
      w_idx = i_head_idx + IDX_W'(k);
      w_ent = i_entries[w_idx];
      if (w_ent.valid && same_word(w_ent.addr, i_query_addr)) begin
        for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
          if (w_ent.wstrb[b]) begin
            o_fwd_mask[b]       = 1'b1;
            o_fwd_data[b*8 +: 8] = w_ent.data[b*8 +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/lsu_store_queue.sv
// Committed-store queue between commit and the DCache write port.
// Up to ENQ_WIDTH stores enter per cycle at the tail; the head entry is
// presented on dc_req_* and retired one per accepted request. Buffered stores
// are byte-forwarded to loads through a combinational lookup.
//   clk, rst_n          : clock, synchronous active-low reset
//   enq_valid/addr/data/wstrb : per-lane store input (lane i needs lane i-1)
//   enq_ready           : free entries >= ENQ_WIDTH (registered state only)
//   dc_req_valid/ready  : head-entry handshake with the DCache
//   dc_req_addr/data/wstrb : head entry contents
//   ld_query_addr       : load address for forwarding
//   fwd_mask/fwd_data   : forwarded bytes
//   sq_count, sq_empty  : occupancy
module lsu_store_queue
  import lsu_store_queue_pkg::*;
#(
  parameter int unsigned SQ_DEPTH  = LSU_STORE_QUEU_SIZE,
  parameter int unsigned ENQ_WIDTH = COMMIT_WIDTH,
  parameter int unsigned ADDR_W    = ADDR_WIDTH,
  parameter int unsigned DATA_W    = DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ENQ_WIDTH-1:0]          enq_valid,
  input  logic [ENQ_WIDTH*ADDR_W-1:0]   enq_addr,
  input  logic [ENQ_WIDTH*DATA_W-1:0]   enq_data,
  input  logic [ENQ_WIDTH*DATA_W/8-1:0] enq_wstrb,
  output logic                          enq_ready,
  output logic                          dc_req_valid,
  input  logic                          dc_req_ready,
  output logic [ADDR_W-1:0]             dc_req_addr,
  output logic [DATA_W-1:0]             dc_req_data,
  output logic [DATA_W/8-1:0]           dc_req_wstrb,
  input  logic [ADDR_W-1:0]             ld_query_addr,
  output logic [DATA_W/8-1:0]           fwd_mask,
  output logic [DATA_W-1:0]             fwd_data,
  output logic [$clog2(SQ_DEPTH):0]     sq_count,
  output logic                          sq_empty
);

  localparam int unsigned IDX_W  = $clog2(SQ_DEPTH);
  localparam int unsigned PTR_W  = IDX_W + 1;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  sq_entry_t        r_entries [SQ_DEPTH];

  logic [PTR_W-1:0] w_count;
  logic [PTR_W-1:0] w_free;
  logic             w_space_ok;
  logic             w_empty;
  logic [IDX_W-1:0] w_head_idx;
  sq_entry_t        w_head;
  logic             w_deq;
  logic [ENQ_WIDTH-1:0] w_enq_lane;
  logic [PTR_W-1:0] w_lane_ptr [ENQ_WIDTH];
  logic [PTR_W-1:0] w_enq_n;
  logic [STRB_W-1:0] w_fwd_mask;
  logic [DATA_W-1:0] w_fwd_data;

  // Wrap bit makes tail-head an exact occupancy in 0..SQ_DEPTH.
  assign w_count    = r_tail - r_head;
  assign w_free     = PTR_W'(SQ_DEPTH) - w_count;
  assign w_space_ok = (w_free >= PTR_W'(ENQ_WIDTH));
  assign w_empty    = (r_head == r_tail);
  assign w_head_idx = r_head[IDX_W-1:0];
  assign w_head     = r_entries[w_head_idx];
  assign w_deq      = rst_n && w_head.valid && dc_req_ready;

  // Lane placement: each accepted lane lands at tail plus the number of
  // accepted lanes before it, so lanes pack in order.
  always_comb begin
    w_enq_n = '0;
    for (int unsigned i = 0; i < ENQ_WIDTH; i++) begin
      w_enq_lane[i] = rst_n && w_space_ok && enq_valid[i];
      w_lane_ptr[i] = r_tail + w_enq_n;
      if (w_enq_lane[i]) begin
        w_enq_n = w_enq_n + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
        r_entries[i] <= '0;
      end
    end else begin
      // Enqueue slots are always free entries, so they never alias the head.
      if (w_deq) begin
        r_entries[w_head_idx].valid <= 1'b0;
        r_head                      <= r_head + PTR_W'(1);
      end
      for (int unsigned i = 0; i < ENQ_WIDTH; i++) begin
        if (w_enq_lane[i]) begin
          r_entries[w_lane_ptr[i][IDX_W-1:0]] <= '{
            valid: 1'b1,
            addr:  enq_addr[i*ADDR_W +: ADDR_W],
            data:  enq_data[i*DATA_W +: DATA_W],
            wstrb: enq_wstrb[i*STRB_W +: STRB_W]
          };
        end
      end
      r_tail <= r_tail + w_enq_n;
    end
  end

  lsu_store_queue_fwd_merge #(
    .SQ_DEPTH (SQ_DEPTH)
  ) u_fwd_merge (
    .i_entries    (r_entries),
    .i_head_idx   (w_head_idx),
    .i_query_addr (ld_query_addr),
    .o_fwd_mask   (w_fwd_mask),
    .o_fwd_data   (w_fwd_data)
  );

  // Outputs are forced to their idle values while reset is asserted, so they
  // are defined even before the first reset edge.
  assign enq_ready    = !rst_n || w_space_ok;
  assign dc_req_valid = rst_n && w_head.valid;
  assign dc_req_addr  = w_head.addr;
  assign dc_req_data  = w_head.data;
  assign dc_req_wstrb = w_head.wstrb;
  assign fwd_mask     = rst_n ? w_fwd_mask : '0;
  assign fwd_data     = rst_n ? w_fwd_data : '0;
  assign sq_count     = rst_n ? w_count : '0;
  assign sq_empty     = !rst_n || w_empty;

endmodule
